// File: rtl/branch_hazard_unit_if.sv
// Pipeline-side bundle for the ID-stage branch hazard unit: stage register fields in,
// forwarding selects, stall/flush controls and performance counters out.
interface branch_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             IFID_isBranch;
    logic [REG_W-1:0] IFID_rs;
    logic [REG_W-1:0] IFID_rt;
    logic [REG_W-1:0] IDEX_rd;
    logic             IDEX_regWrite;
    logic             IDEX_memRead;
    logic [REG_W-1:0] EXMEM_rd;
    logic             EXMEM_regWrite;
    logic             EXMEM_memRead;
    logic [REG_W-1:0] MEMWB_rd;
    logic             MEMWB_regWrite;
    logic             branch_taken;
    logic [1:0]       branchFWDA;
    logic [1:0]       branchFWDB;
    logic             stall;
    logic             flush_ifid;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output IFID_isBranch, IFID_rs, IFID_rt, IDEX_rd, IDEX_regWrite, IDEX_memRead,
               EXMEM_rd, EXMEM_regWrite, EXMEM_memRead, MEMWB_rd, MEMWB_regWrite, branch_taken,
        input  branchFWDA, branchFWDB, stall, flush_ifid, stall_cycles, taken_count
    );

    modport slave (
        input  IFID_isBranch, IFID_rs, IFID_rt, IDEX_rd, IDEX_regWrite, IDEX_memRead,
               EXMEM_rd, EXMEM_regWrite, EXMEM_memRead, MEMWB_rd, MEMWB_regWrite, branch_taken,
        output branchFWDA, branchFWDB, stall, flush_ifid, stall_cycles, taken_count
    );
endinterface

// File: rtl/branch_hazard_unit.sv
// ID-stage branch forwarding select, multi-cycle branch stall FSM, taken-branch IF/ID flush
// and saturating stall/taken counters for the 5-stage pipeline.
module branch_hazard_unit #(
    parameter int REG_W         = 5,
    parameter int ALU_BR_STALL  = 1,
    parameter int LOAD_BR_STALL = 2,
    parameter int MEM_BR_STALL  = 1,
    parameter int CNT_W         = 16
) (
    input logic              Clock,
    input logic              Reset_n,
    branch_hazard_unit_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [2:0]       needA, needB, need;
    logic             stallInt, flushInt;
    logic [CNT_W-1:0] stallCnt, takenCnt;

    // Register 0 is hardwired, so a write to it is never a real producer.
    function automatic logic hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src,
                                 input logic wr);
        return wr && (rd == src) && (rd != '0);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
        if (hit(bus.EXMEM_rd, src, bus.EXMEM_regWrite) && !bus.EXMEM_memRead) return 2'b01;
        else if (hit(bus.MEMWB_rd, src, bus.MEMWB_regWrite))                  return 2'b10;
        else                                                                  return 2'b00;
    endfunction

    function automatic logic [2:0] needOf(input logic [REG_W-1:0] src);
        if (hit(bus.IDEX_rd, src, bus.IDEX_regWrite) && bus.IDEX_memRead) return 3'(LOAD_BR_STALL);
        else if (hit(bus.IDEX_rd, src, bus.IDEX_regWrite))                return 3'(ALU_BR_STALL);
        else if (hit(bus.EXMEM_rd, src, bus.EXMEM_regWrite) && bus.EXMEM_memRead)
                                                                          return 3'(MEM_BR_STALL);
        else                                                              return 3'd0;
    endfunction

    always_comb begin
        needA    = needOf(bus.IFID_rs);
        needB    = needOf(bus.IFID_rt);
        need     = bus.IFID_isBranch ? ((needA > needB) ? needA : needB) : 3'd0;
        stallInt = (state == HOLD) || (need != 3'd0);
        // A taken branch seen during a stall is resolved again once operands are ready.
        flushInt = bus.branch_taken && bus.IFID_isBranch && !stallInt;
    end

    assign bus.branchFWDA   = fwdSel(bus.IFID_rs);
    assign bus.branchFWDB   = fwdSel(bus.IFID_rt);
    assign bus.stall        = stallInt;
    assign bus.flush_ifid   = flushInt;
    assign bus.stall_cycles = stallCnt;
    assign bus.taken_count  = takenCnt;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            stallCnt <= '0;
            takenCnt <= '0;
        end else begin
            case (state)
                IDLE: if (need > 3'd1) begin
                    cnt   <= need - 3'd1;
                    state <= HOLD;
                end
                HOLD: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (stallInt && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            if (flushInt && takenCnt != '1) takenCnt <= takenCnt + 1'b1;
        end
    end
endmodule
